// File: rtl/pixel_window_capture_if.sv
// Packed-word stream leaving the frame grabber: FWFT head word with valid/ready.
interface pixel_window_capture_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] o_Word;
  logic              o_Word_Valid;
  logic              i_Word_Ready;

  modport master (output o_Word, output o_Word_Valid, input i_Word_Ready);
  modport slave  (input o_Word, input o_Word_Valid, output i_Word_Ready);
endinterface

// File: rtl/pixel_window_capture.sv
// Snoops the raster pixel stream, packs a rectangular window MSB-first into
// words and buffers them in a small FWFT FIFO for a valid/ready consumer.
module pixel_window_capture #(
  parameter int PIX_W      = 2,
  parameter int WORD_W     = 32,
  parameter int COORD_W    = 10,
  parameter int WIN_X0     = 16,
  parameter int WIN_Y0     = 0,
  parameter int WIN_W      = 256,
  parameter int WIN_H      = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Arm,
  input  logic                   i_Continuous,
  input  logic                   i_Pixel_Valid,
  input  logic [COORD_W-1:0]     i_Row,
  input  logic [COORD_W-1:0]     i_Column,
  input  logic [PIX_W-1:0]       i_Pixel,
  pixel_window_capture_if.master m_word,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic                   o_Overflow,
  output logic [CNT_W-1:0]       o_Word_Count,
  output logic [CNT_W-1:0]       o_Frame_Count
);

  localparam int PPW  = WORD_W / PIX_W;
  localparam int PC_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SR_W = WORD_W - PIX_W;

  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PPW - 1);
  localparam logic [COORD_W:0] X_LO    = (COORD_W + 1)'(WIN_X0);
  localparam logic [COORD_W:0] X_HI    = (COORD_W + 1)'(WIN_X0 + WIN_W);
  localparam logic [COORD_W:0] X_LAST  = (COORD_W + 1)'(WIN_X0 + WIN_W - 1);
  localparam logic [COORD_W:0] Y_LO    = (COORD_W + 1)'(WIN_Y0);
  localparam logic [COORD_W:0] Y_HI    = (COORD_W + 1)'(WIN_Y0 + WIN_H);
  localparam logic [COORD_W:0] Y_LAST  = (COORD_W + 1)'(WIN_Y0 + WIN_H - 1);
  localparam logic [AW:0]      FULL_N  = (AW + 1)'(FIFO_DEPTH);

  generate
    if (WORD_W % PIX_W != 0) begin : g_err_word
      $error("WORD_W must be a multiple of PIX_W");
    end
    if (PPW < 2) begin : g_err_ppw
      $error("a word must hold at least two pixels");
    end
    if (WIN_W % PPW != 0) begin : g_err_win
      $error("WIN_W must be a multiple of WORD_W/PIX_W");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                  r_cont;
  logic                  r_overflow;
  logic [CNT_W-1:0]      r_word_count;
  logic [CNT_W-1:0]      r_frame_count;
  logic [SR_W-1:0]       r_sr;
  logic [PC_W-1:0]       r_pix_cnt;
  logic [WORD_W-1:0]     r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;

  logic [COORD_W:0]      w_row;
  logic [COORD_W:0]      w_col;
  logic                  w_x_ge;
  logic                  w_y_ge;
  logic                  w_in_win;
  logic                  w_sof;
  logic                  w_eof_pix;
  logic                  w_arm_ok;
  logic                  w_take;
  logic                  w_frame_end;
  logic                  w_word_done;
  logic [WORD_W-1:0]     w_push_word;
  logic [AW:0]           w_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;

  // Coordinates are widened by one bit so WIN_X0+WIN_W cannot wrap.
  assign w_row = {1'b0, i_Row};
  assign w_col = {1'b0, i_Column};

  generate
    if (WIN_X0 == 0) begin : g_x_ge_zero
      assign w_x_ge = 1'b1;
    end else begin : g_x_ge_cmp
      assign w_x_ge = (w_col >= X_LO);
    end
    if (WIN_Y0 == 0) begin : g_y_ge_zero
      assign w_y_ge = 1'b1;
    end else begin : g_y_ge_cmp
      assign w_y_ge = (w_row >= Y_LO);
    end
  endgenerate

  assign w_in_win  = i_Pixel_Valid && w_y_ge && (w_row < Y_HI) && w_x_ge && (w_col < X_HI);
  assign w_sof     = i_Pixel_Valid && (w_row == Y_LO) && (w_col == X_LO);
  assign w_eof_pix = (w_row == Y_LAST) && (w_col == X_LAST);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_arm_ok     = 1'b0;
    w_take       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_Arm) begin
          w_arm_ok     = 1'b1;
          w_state_next = S_WAIT_SOF;
        end
      end
      S_WAIT_SOF: begin
        if (w_sof) begin
          w_take       = 1'b1;
          w_state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_take = w_in_win;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // A one-pixel window makes the start pixel also the last one.
    if (w_take && w_eof_pix) begin
      w_state_next = r_cont ? S_WAIT_SOF : S_DONE;
    end
  end

  assign w_frame_end = w_take && w_eof_pix;
  assign w_word_done = w_take && (r_pix_cnt == PC_LAST);
  assign w_push_word = {r_sr, i_Pixel};

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_sr      <= '0;
      r_pix_cnt <= '0;
    end else if (w_take) begin
      r_sr      <= SR_W'({r_sr, i_Pixel});
      r_pix_cnt <= w_word_done ? '0 : r_pix_cnt + 1'b1;
    end
  end

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_count == FULL_N);
  assign w_pop   = !w_empty && m_word.i_Word_Ready;
  assign w_push  = w_word_done && (!w_full || w_pop);
  assign w_drop  = w_word_done && !w_push;

  // Shallow FIFO lives in distributed RAM so the head word is readable in
  // the cycle right after the push (first-word fall-through).
  always_ff @(posedge i_Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_push_word;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_cont        <= 1'b0;
      r_overflow    <= 1'b0;
      r_word_count  <= '0;
      r_frame_count <= '0;
    end else if (w_arm_ok) begin
      r_cont        <= i_Continuous;
      r_overflow    <= 1'b0;
      r_word_count  <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_push && (r_word_count != '1)) begin
        r_word_count <= r_word_count + 1'b1;
      end
      if (w_frame_end && (r_frame_count != '1)) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

  assign m_word.o_Word       = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign m_word.o_Word_Valid = !w_empty;
  assign o_Busy              = (r_state == S_WAIT_SOF) || (r_state == S_CAPTURE);
  assign o_Done              = (r_state == S_DONE);
  assign o_Overflow          = r_overflow;
  assign o_Word_Count        = r_word_count;
  assign o_Frame_Count       = r_frame_count;

endmodule

// File: tb/tb_pixel_window_capture.sv
// Bench: two capture instances (FIFO depth 4 and 2) on one raster stream; the
// depth-4 instance is tracked every cycle by a queue-based reference model.
module tb_pixel_window_capture;

  localparam int PIX_W   = 2;
  localparam int WORD_W  = 32;
  localparam int COORD_W = 10;
  localparam int X0      = 16;
  localparam int Y0      = 0;
  localparam int WIN_W   = 32;
  localparam int WIN_H   = 2;
  localparam int DEPTH_A = 4;
  localparam int DEPTH_B = 2;
  localparam int CNT_W   = 16;
  localparam int PPW     = WORD_W / PIX_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [WORD_W-1:0] RAMP_WORD = 32'h1B1B1B1B;

  logic               clk;
  logic               rst;
  logic               arm_a, cont_a, arm_b, cont_b;
  logic               pv;
  logic [COORD_W-1:0] row, col;
  logic [PIX_W-1:0]   pix;
  logic               busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [CNT_W-1:0]   wc_a, fc_a, wc_b, fc_b;

  pixel_window_capture_if #(.WORD_W(WORD_W)) if_a ();
  pixel_window_capture_if #(.WORD_W(WORD_W)) if_b ();

  pixel_window_capture #(
    .PIX_W(PIX_W), .WORD_W(WORD_W), .COORD_W(COORD_W), .WIN_X0(X0), .WIN_Y0(Y0),
    .WIN_W(WIN_W), .WIN_H(WIN_H), .FIFO_DEPTH(DEPTH_A), .CNT_W(CNT_W)
  ) dut_a (
    .i_Clk(clk), .i_Reset(rst), .i_Arm(arm_a), .i_Continuous(cont_a),
    .i_Pixel_Valid(pv), .i_Row(row), .i_Column(col), .i_Pixel(pix),
    .m_word(if_a), .o_Busy(busy_a), .o_Done(done_a), .o_Overflow(ovf_a),
    .o_Word_Count(wc_a), .o_Frame_Count(fc_a)
  );

  pixel_window_capture #(
    .PIX_W(PIX_W), .WORD_W(WORD_W), .COORD_W(COORD_W), .WIN_X0(X0), .WIN_Y0(Y0),
    .WIN_W(WIN_W), .WIN_H(WIN_H), .FIFO_DEPTH(DEPTH_B), .CNT_W(CNT_W)
  ) dut_b (
    .i_Clk(clk), .i_Reset(rst), .i_Arm(arm_b), .i_Continuous(cont_b),
    .i_Pixel_Valid(pv), .i_Row(row), .i_Column(col), .i_Pixel(pix),
    .m_word(if_b), .o_Busy(busy_b), .o_Done(done_b), .o_Overflow(ovf_b),
    .o_Word_Count(wc_b), .o_Frame_Count(fc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 never, 3 only at (0,31)

  // Reference model: capture progress as a list of pending pixels, FIFO as a queue.
  int                m_mode;  // 0 idle, 1 waiting for frame start, 2 capturing, 3 done
  bit                m_cont, m_ovf;
  int                m_wc, m_fc;
  logic [PIX_W-1:0]  m_pix[$];
  logic [WORD_W-1:0] m_fifo[$];

  logic [WORD_W-1:0] pop_a[$];
  logic [WORD_W-1:0] pop_b[$];

  task automatic model_step();
    bit pop, take, push_req, in_win;
    int r, c;
    logic [WORD_W-1:0] w;
    r = int'(row);
    c = int'(col);
    w = '0;
    if (rst) begin
      m_mode = 0; m_cont = 0; m_ovf = 0; m_wc = 0; m_fc = 0;
      m_pix.delete(); m_fifo.delete();
      return;
    end
    pop = (m_fifo.size() != 0) && (if_a.i_Word_Ready == 1'b1);
    in_win = pv && r >= Y0 && r < Y0 + WIN_H && c >= X0 && c < X0 + WIN_W;
    take = 0;
    push_req = 0;
    case (m_mode)
      0, 3: if (arm_a) begin
        m_mode = 1; m_cont = cont_a; m_ovf = 0; m_wc = 0; m_fc = 0;
      end
      1: if (pv && r == Y0 && c == X0) begin take = 1; m_mode = 2; end
      2: take = in_win;
      default: ;
    endcase
    if (take) begin
      m_pix.push_back(pix);
      if (m_pix.size() == PPW) begin
        foreach (m_pix[i]) w = (w << PIX_W) | WORD_W'(m_pix[i]);
        push_req = 1;
        m_pix.delete();
      end
      if (r == Y0 + WIN_H - 1 && c == X0 + WIN_W - 1) begin
        if (m_fc < CNT_MAX) m_fc++;
        m_mode = m_cont ? 1 : 3;
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (push_req) begin
      if (m_fifo.size() < DEPTH_A) begin
        m_fifo.push_back(w);
        if (m_wc < CNT_MAX) m_wc++;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic check_cycle();
    logic [WORD_W-1:0] e_word;
    logic [CNT_W-1:0]  e_wc, e_fc;
    bit e_valid, e_busy, e_done;
    e_valid = (m_fifo.size() != 0);
    e_word  = e_valid ? m_fifo[0] : '0;
    e_busy  = (m_mode == 1 || m_mode == 2);
    e_done  = (m_mode == 3);
    e_wc    = CNT_W'(m_wc);
    e_fc    = CNT_W'(m_fc);
    n_cmp++;
    if ({if_a.o_Word, if_a.o_Word_Valid, busy_a, done_a, ovf_a, wc_a, fc_a} !==
        {e_word, e_valid, e_busy, e_done, m_ovf, e_wc, e_fc}) begin
      n_fail++;
      $display("FAIL model_cycle%0d: got word=%h v=%b busy=%b done=%b ovf=%b wc=%0d fc=%0d, want word=%h v=%b busy=%b done=%b ovf=%b wc=%0d fc=%0d",
               cyc, if_a.o_Word, if_a.o_Word_Valid, busy_a, done_a, ovf_a, wc_a, fc_a,
               e_word, e_valid, e_busy, e_done, m_ovf, e_wc, e_fc);
    end
  endtask

  task automatic chk(string name, logic [WORD_W-1:0] act, logic [WORD_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    if (!rst && if_a.o_Word_Valid === 1'b1 && if_a.i_Word_Ready === 1'b1) begin
      pop_a.push_back(if_a.o_Word);
      $display("cycle %0d: dut_a pop word=%h", cyc, if_a.o_Word);
    end
    if (!rst && if_b.o_Word_Valid === 1'b1 && if_b.i_Word_Ready === 1'b1) begin
      pop_b.push_back(if_b.o_Word);
      $display("cycle %0d: dut_b pop word=%h", cyc, if_b.o_Word);
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic drive_pix(bit v, int r, int c, logic [PIX_W-1:0] p, bit a);
    pv = v; row = COORD_W'(r); col = COORD_W'(c); pix = p; arm_a = a;
    case (rdy_mode)
      0: if_a.i_Word_Ready = 1'b1;
      1: if_a.i_Word_Ready = 1'($urandom);
      2: if_a.i_Word_Ready = 1'b0;
      default: if_a.i_Word_Ready = (v && r == 0 && c == 31);
    endcase
    tick();
    arm_a = 1'b0;
  endtask

  task automatic blank(int n);
    for (int i = 0; i < n; i++)
      drive_pix(1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), PIX_W'($urandom), 1'b0);
  endtask

  task automatic arm_in_blank();
    drive_pix(1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), PIX_W'($urandom), 1'b1);
  endtask

  // Shortened raster: rows 0-3 plus the last row, columns 0-63 plus the last column.
  task automatic drive_frame(int arm_r, int arm_c, bit rand_pix, bit gaps);
    int rows[5];
    int cc;
    logic [PIX_W-1:0] p;
    rows = '{0, 1, 2, 3, 479};
    for (int ri = 0; ri < 5; ri++) begin
      for (int c = 0; c <= 64; c++) begin
        cc = (c == 64) ? 639 : c;
        if (gaps && $urandom_range(0, 7) == 0) blank(1);
        p = rand_pix ? PIX_W'($urandom) : PIX_W'(cc);
        drive_pix(1'b1, rows[ri], cc, p, (rows[ri] == arm_r && cc == arm_c));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    blank(2);
    rst = 1'b0;
  endtask

  typedef struct {
    bit do_rst;
    int arm_r;
    int arm_c;
    bit cont;
    int frames;
    bit rand_pix;
    int rdy;
    int exp_pops;
    int exp_wc;
    int exp_fc;
    bit exp_done;
    bit exp_busy;
    int exp_ovf;
  } scen_t;

  scen_t tbl[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; arm_a = 0; cont_a = 0; arm_b = 0; cont_b = 0;
    pv = 0; row = '0; col = '0; pix = '0;
    if_a.i_Word_Ready = 1'b1;
    if_b.i_Word_Ready = 1'b0;
    m_mode = 0; m_cont = 0; m_ovf = 0; m_wc = 0; m_fc = 0;

    // arm_r<0: arm during blanking; exp_* of -1 means not checked
    tbl[0] = '{1, -1, -1, 0, 1, 0, 0, 4, 4, 1, 1, 0, 0};
    tbl[1] = '{0, 1, 20, 0, 2, 0, 0, 4, 4, 1, 1, 0, 0};
    tbl[2] = '{0, -1, -1, 0, 1, 1, 1, 4, 4, 1, 1, 0, 0};
    tbl[3] = '{1, -1, -1, 1, 3, 0, 0, 12, 12, 3, 0, 1, 0};
    tbl[4] = '{1, -1, -1, 1, 2, 1, 1, -1, -1, 2, 0, 1, -1};

    do_reset();
    chk("reset_word", if_a.o_Word, '0);
    chk("reset_valid", 32'(if_a.o_Word_Valid), 0);
    chk("reset_busy_done", 32'({busy_a, done_a, ovf_a}), 0);

    for (int k = 0; k < 5; k++) begin
      if (tbl[k].do_rst) do_reset();
      rdy_mode = tbl[k].rdy;
      cont_a = tbl[k].cont;
      blank(3);
      pop_a.delete();
      if (tbl[k].arm_r < 0) arm_in_blank();
      for (int f = 0; f < tbl[k].frames; f++)
        drive_frame((f == 0) ? tbl[k].arm_r : -1, tbl[k].arm_c, tbl[k].rand_pix, 1'b1);
      rdy_mode = 0;
      blank(20);
      $display("scenario %0d: pops=%0d wc=%0d fc=%0d done=%b busy=%b ovf=%b",
               k, pop_a.size(), wc_a, fc_a, done_a, busy_a, ovf_a);
      if (tbl[k].exp_wc >= 0) chk($sformatf("s%0d_word_count", k), 32'(wc_a), tbl[k].exp_wc);
      chk($sformatf("s%0d_frame_count", k), 32'(fc_a), tbl[k].exp_fc);
      chk($sformatf("s%0d_done", k), 32'(done_a), 32'(tbl[k].exp_done));
      chk($sformatf("s%0d_busy", k), 32'(busy_a), 32'(tbl[k].exp_busy));
      if (tbl[k].exp_ovf >= 0) chk($sformatf("s%0d_overflow", k), 32'(ovf_a), tbl[k].exp_ovf);
      if (tbl[k].exp_pops >= 0) chk($sformatf("s%0d_pops", k), pop_a.size(), tbl[k].exp_pops);
      if (!tbl[k].rand_pix) begin
        int bad;
        bad = 0;
        foreach (pop_a[i]) if (pop_a[i] !== RAMP_WORD) bad++;
        chk($sformatf("s%0d_bad_words", k), bad, 0);
      end
    end

    // Full FIFO: the fifth word is pushed on the same edge as a pop.
    do_reset();
    cont_a = 1; rdy_mode = 2;
    arm_in_blank();
    drive_frame(-1, -1, 1'b1, 1'b0);
    chk("full_fill_count", 32'(wc_a), 4);
    chk("full_fill_ovf", 32'(ovf_a), 0);
    rdy_mode = 3;
    drive_frame(-1, -1, 1'b1, 1'b0);
    chk("full_pushpop_count", 32'(wc_a), 5);
    chk("full_later_drops_ovf", 32'(ovf_a), 1);
    rdy_mode = 0;
    pop_a.delete();
    blank(10);
    chk("full_drain_pops", pop_a.size(), 4);

    // Reset after ten captured pixels, then a clean re-arm.
    do_reset();
    cont_a = 0; rdy_mode = 0;
    arm_in_blank();
    for (int c = 0; c < 26; c++) drive_pix(1'b1, 0, c, PIX_W'(c), 1'b0);
    rst = 1'b1;
    drive_pix(1'b1, 0, 26, PIX_W'(26), 1'b0);
    rst = 1'b0;
    chk("midrst_word", if_a.o_Word, '0);
    chk("midrst_valid", 32'(if_a.o_Word_Valid), 0);
    chk("midrst_busy", 32'(busy_a), 0);
    chk("midrst_done_ovf", 32'({done_a, ovf_a}), 0);
    chk("midrst_counts", 32'({wc_a, fc_a}), 0);
    blank(5);
    pop_a.delete();
    arm_in_blank();
    drive_frame(-1, -1, 1'b0, 1'b1);
    blank(10);
    chk("rearm_pops", pop_a.size(), 4);
    chk("rearm_first_word", (pop_a.size() > 0) ? pop_a[0] : 'x, RAMP_WORD);

    // Backpressure on the depth-2 instance.
    do_reset();
    cont_b = 0;
    if_b.i_Word_Ready = 1'b0;
    arm_b = 1'b1;
    blank(1);
    arm_b = 1'b0;
    drive_frame(-1, -1, 1'b0, 1'b1);
    blank(3);
    chk("bp_overflow", 32'(ovf_b), 1);
    chk("bp_word_count", 32'(wc_b), 2);
    chk("bp_frame_done", 32'({fc_b, done_b, busy_b}), {14'd0, 16'd1, 1'b1, 1'b0});
    chk("bp_valid", 32'(if_b.o_Word_Valid), 1);
    pop_b.delete();
    if_b.i_Word_Ready = 1'b1;
    blank(10);
    chk("bp_drained", pop_b.size(), 2);
    chk("bp_word0", (pop_b.size() > 0) ? pop_b[0] : 'x, RAMP_WORD);
    chk("bp_word1", (pop_b.size() > 1) ? pop_b[1] : 'x, RAMP_WORD);
    chk("bp_empty", 32'(if_b.o_Word_Valid), 0);
    arm_b = 1'b1;
    blank(1);
    arm_b = 1'b0;
    chk("bp_rearm_ovf", 32'(ovf_b), 0);
    chk("bp_rearm_count", 32'(wc_b), 0);
    chk("bp_rearm_busy", 32'(busy_b), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
